// File: rtl/serial_adder_16.sv
// Nibble-serial adder: adds two W-bit operands one 4-bit slice per cycle, LSB first,
// through a single 4-bit ripple-carry adder, with valid/ready handshakes on both sides.

module adder_4_bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [4:0] w_carry;

    always_comb begin
        w_carry    = '0;
        o_sum      = '0;
        w_carry[0] = i_cin;
        for (int i = 0; i < 4; i++) begin
            o_sum[i]     = i_a[i] ^ i_b[i] ^ w_carry[i];
            w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout = w_carry[4];
endmodule

module serial_adder_16 #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf,
    output logic                   busy
);
    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic [IdxW-1:0] r_idx;
    logic            r_carry;
    logic            r_cout;
    logic            r_ovf;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;

    logic [3:0]      w_a_slice;
    logic [3:0]      w_b_slice;
    logic [3:0]      w_slice_sum;
    logic            w_slice_cout;
    logic            w_msb_cin;

    assign w_a_slice = 4'(r_a >> {r_idx, 2'b00});
    assign w_b_slice = 4'(r_b >> {r_idx, 2'b00});

    adder_4_bit u_adder (
        .i_a    (w_a_slice),
        .i_b    (w_b_slice),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

    // Carry into bit 3 of the slice, recovered from the sum bit; only meaningful on the top slice.
    assign w_msb_cin = w_a_slice[3] ^ w_b_slice[3] ^ w_slice_sum[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_carry    <= cin;
                        r_idx      <= '0;
                        r_state    <= StCalc;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                StCalc: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_slice_sum;
                    r_carry                    <= w_slice_cout;
                    r_idx                      <= r_idx + 1'b1;
                    if (r_idx == LastIdx) begin
                        r_cout      <= w_slice_cout;
                        r_ovf       <= w_msb_cin ^ w_slice_cout;
                        r_state     <= StDone;
                        r_out_valid <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_state     <= StIdle;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
endmodule
